// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with optional zero register,
// write-to-read forwarding, registered read ports and a debug port.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [SIZE-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SIZE-1:0]  raddr1,
  input  logic [SIZE-1:0]  raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic [SIZE-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** SIZE;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;
  logic [WIDTH-1:0] next1;
  logic [WIDTH-1:0] next2;

  // Reset and zero-register writes never reach storage or forwarding.
  assign wr_ok = reset && we &&
                 !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    stored1 = regs[raddr1];
    stored2 = regs[raddr2];
    dbg_data = regs[dbg_addr];
    if (ZERO_REG && (raddr1 == '0)) begin
      stored1 = '0;
    end
    if (ZERO_REG && (raddr2 == '0)) begin
      stored2 = '0;
    end
    if (ZERO_REG && (dbg_addr == '0)) begin
      dbg_data = '0;
    end
  end

  // Value each read port sees: forwarded write or stored contents.
  always_comb begin
    next1 = stored1;
    next2 = stored2;
    if (BYPASS && wr_ok && (waddr == raddr1)) begin
      next1 = wdata;
    end
    if (BYPASS && wr_ok && (waddr == raddr2)) begin
      next2 = wdata;
    end
  end

  generate
    if (REG_READ) begin : g_rr
      always_ff @(posedge clk) begin
        if (!reset) begin
          rdata1 <= '0;
          rdata2 <= '0;
        end else begin
          rdata1 <= next1;
          rdata2 <= next2;
        end
      end
    end else begin : g_cr
      assign rdata1 = next1;
      assign rdata2 = next2;
    end
  endgenerate

endmodule
